// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// AXI response codes and the bus FSM state type.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR      = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// AXI4-Lite read/write channels between the MEM stage (master) and memory (slave).
// Handshake: a beat transfers on a rising clk edge where valid and ready are both 1;
// the source holds valid and its payload stable until that edge.
interface mem_access_stage_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/mem_align_unit.sv
// Combinational data alignment: load extension, store lane replication and
// byte strobes, and the misaligned-access check.
module mem_align_unit
    import mem_access_stage_pkg::*;
(
    input  logic        in_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misalign
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        is_byte;
    logic        is_half;

    always_comb begin
        rbyte   = rdata[{addr_lo, 3'b000} +: 8];
        rhalf   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        is_byte = (funct3[1:0] == 2'b00);
        is_half = (funct3[1:0] == 2'b01);

        case (funct3)
            F3_LB:   load_data = {{24{rbyte[7]}}, rbyte};
            F3_LH:   load_data = {{16{rhalf[15]}}, rhalf};
            F3_LBU:  load_data = {24'd0, rbyte};
            F3_LHU:  load_data = {16'd0, rhalf};
            default: load_data = rdata;
        endcase

        // Lanes are replicated so the slave can pick any byte lane by strobe.
        case (funct3)
            F3_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
                wstrb = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase

        misalign = in_valid & (is_load | is_store) &
                   ((is_half & addr_lo[0]) | (~is_half & ~is_byte & (addr_lo != 2'b00)));
    end
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one AXI4-Lite access per load/store with a stall request
// until it completes; non-memory instructions pass straight through.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_commit,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_csr_out,
    input  logic        in_write_gpr,
    input  logic        in_write_csr,
    input  logic        in_mem_to_reg,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_csr_rd,
    input  logic        in_system_halt,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_wdata,
    input  logic        stall_me,
    input  logic        flush_me,
    output logic        out_commit,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_alu_out,
    output logic [31:0] out_csr_out,
    output logic        out_write_gpr,
    output logic        out_write_csr,
    output logic        out_mem_to_reg,
    output logic [4:0]  out_rd,
    output logic [1:0]  out_csr_rd,
    output logic        out_system_halt,
    output logic [31:0] out_rdata,
    output logic        out_misalign,
    output logic        busy,
    output mem_state_e  dbg_state,
    mem_access_stage_if.master bus
);
    mem_state_e  state_q, state_d;
    logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d, flushed_q, flushed_d;
    logic [31:0] load_ext, store_data;
    logic [3:0]  store_strb;
    logic        memop;
    logic        unused_resp;

    mem_align_unit u_align (
        .in_valid   (in_valid),
        .is_load    (in_mem_read),
        .is_store   (in_mem_write),
        .funct3     (in_funct3),
        .addr_lo    (in_alu_out[1:0]),
        .rdata      (bus.rdata),
        .store_data (in_wdata),
        .load_data  (load_ext),
        .wdata      (store_data),
        .wstrb      (store_strb),
        .misalign   (out_misalign)
    );

    assign memop = in_valid & (in_mem_read | in_mem_write) & ~out_misalign;

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        flushed_d = flushed_q;
        case (state_q)
            S_IDLE: begin
                if (memop) begin
                    if (in_mem_read) begin
                        state_d  = S_RD_ADDR;
                        araddr_d = in_alu_out;
                    end else begin
                        state_d  = S_WR;
                        awaddr_d = in_alu_out;
                        wdata_d  = store_data;
                        wstrb_d  = store_strb;
                    end
                end
            end
            S_RD_ADDR: if (bus.arready) state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (bus.rvalid) begin
                    rdata_d = load_ext;
                    state_d = S_DONE;
                end
            end
            S_WR: begin
                aw_done_d = aw_done_q | bus.awready;
                w_done_d  = w_done_q | bus.wready;
                if (aw_done_d && w_done_d) begin
                    state_d   = S_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_WR_RESP: if (bus.bvalid) state_d = S_DONE;
            S_DONE:    if (!stall_me) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // A flush never aborts the bus access; it only remembers to drop the commit.
        if (state_q == S_DONE && state_d == S_IDLE) begin
            flushed_d = 1'b0;
        end else if (flush_me && (state_q != S_IDLE || memop)) begin
            flushed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            flushed_q <= flushed_d;
        end
    end

    assign bus.araddr  = araddr_q;
    assign bus.arvalid = (state_q == S_RD_ADDR);
    assign bus.rready  = (state_q == S_RD_DATA);
    assign bus.awaddr  = awaddr_q;
    assign bus.awvalid = (state_q == S_WR) & ~aw_done_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wvalid  = (state_q == S_WR) & ~w_done_q;
    assign bus.bready  = (state_q == S_WR_RESP);
    // Error responses complete the access like OKAY.
    assign unused_resp = ^{bus.rresp, bus.bresp};

    assign busy      = memop & (state_q != S_DONE);
    assign dbg_state = state_q;
    assign out_rdata = rdata_q;
    // A flush arriving in the DONE cycle itself squashes the commit too.
    assign out_commit = memop ? (in_commit & (state_q == S_DONE) & ~flushed_q & ~flush_me)
                              : (in_commit & ~flush_me);

    assign out_pc          = in_pc;
    assign out_inst        = in_inst;
    assign out_alu_out     = in_alu_out;
    assign out_csr_out     = in_csr_out;
    assign out_write_gpr   = in_write_gpr;
    assign out_write_csr   = in_write_csr;
    assign out_mem_to_reg  = in_mem_to_reg;
    assign out_rd          = in_rd;
    assign out_csr_rd      = in_csr_rd;
    assign out_system_halt = in_system_halt;
endmodule
